// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD hex writer slice.
//   - state_t        : command sequencer state encoding
//   - ASCII_0/ASCII_A: base characters for hex digit conversion
//   - hex_to_ascii() : 4-bit nibble to uppercase ASCII hex digit
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_BOOT_PULSE = 3'd0,
    ST_BOOT_WAIT  = 3'd1,
    ST_READY      = 3'd2,
    ST_CLR_PULSE  = 3'd3,
    ST_CLR_WAIT   = 3'd4,
    ST_CHR_PULSE  = 3'd5,
    ST_CHR_WAIT   = 3'd6
  } state_t;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return ASCII_0 + {4'h0, nibble};
    end
    return ASCII_A + {4'h0, nibble} - 8'd10;
  endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// lcd_wait_timer: 32-bit down-counter shared by all wait states.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   i_load        : load i_load_val and start counting (one cycle)
//   i_load_val    : wait length minus one
//   o_done        : high for the one cycle in which the count reaches zero
// A load of N keeps the timer running for N+1 cycles, so a load of 0 gives
// a one-cycle wait.
module lcd_wait_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  output logic        o_done
);

  logic [31:0] r_count;
  logic        r_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= 32'd0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_count  <= i_load_val;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == 32'd0) begin
        r_active <= 1'b0;
      end else begin
        r_count <= r_count - 32'd1;
      end
    end
  end

  assign o_done = r_active && (r_count == 32'd0);

endmodule

// File: rtl/lcd_hex_writer.sv
// lcd_hex_writer: command sequencer in front of a character LCD controller.
// Boots the LCD, then on each accepted start clears the display and writes
// the latched 32-bit value as 8 uppercase hex characters, MS nibble first.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : display request, only honoured while busy is low
//   value[31:0]  : word to display, latched when start is accepted
//   busy         : high while booting or writing
//   lcd_init     : one-cycle init pulse to the LCD controller
//   lcd_enviar   : one-cycle write-character pulse (character on lcd_info)
//   lcd_limpiar  : one-cycle clear-display pulse
//   lcd_info[7:0]: ASCII character, held until the next character pulse
// All outputs are registered from the next-state decode so they line up
// with the state they belong to.
module lcd_hex_writer
  import lcd_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES  = 1000000,
  parameter int unsigned CLEAR_CYCLES = 82000,
  parameter int unsigned CHAR_CYCLES  = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        lcd_init,
  output logic        lcd_enviar,
  output logic        lcd_limpiar,
  output logic [7:0]  lcd_info
);

  // Timer holds "cycles minus one"; a zero-length wait still spends one cycle.
  localparam logic [31:0] BOOT_LOAD  = (BOOT_CYCLES  == 0) ? 32'd0 : 32'(BOOT_CYCLES  - 1);
  localparam logic [31:0] CLEAR_LOAD = (CLEAR_CYCLES == 0) ? 32'd0 : 32'(CLEAR_CYCLES - 1);
  localparam logic [31:0] CHAR_LOAD  = (CHAR_CYCLES  == 0) ? 32'd0 : 32'(CHAR_CYCLES  - 1);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_next;
  logic [31:0] r_value_q;
  logic        w_latch;
  logic        w_load;
  logic [31:0] w_load_val;
  logic        w_done;
  logic [3:0]  w_nibble;

  logic        r_busy;
  logic        r_lcd_init;
  logic        r_lcd_enviar;
  logic        r_lcd_limpiar;
  logic [7:0]  r_lcd_info;

  lcd_wait_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT_PULSE;
      r_idx   <= 3'd7;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
    end
  end

  // Data register: only the accept strobe matters, no reset needed.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_value_q <= value;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    w_latch    = 1'b0;
    case (r_state)
      // The init pulse register starts at 0 out of reset, so BOOT_PULSE
      // holds one extra edge to launch the pulse, then moves on while it
      // is visible.
      ST_BOOT_PULSE: if (r_lcd_init) w_next = ST_BOOT_WAIT;
      ST_BOOT_WAIT:  if (w_done) w_next = ST_READY;
      ST_READY: begin
        if (start) begin
          w_next     = ST_CLR_PULSE;
          w_idx_next = 3'd7;
          w_latch    = 1'b1;
        end
      end
      ST_CLR_PULSE:  w_next = ST_CLR_WAIT;
      ST_CLR_WAIT:   if (w_done) w_next = ST_CHR_PULSE;
      ST_CHR_PULSE:  w_next = ST_CHR_WAIT;
      ST_CHR_WAIT: begin
        if (w_done) begin
          if (r_idx == 3'd0) begin
            w_next = ST_READY;
          end else begin
            w_next     = ST_CHR_PULSE;
            w_idx_next = r_idx - 3'd1;
          end
        end
      end
      default: w_next = ST_BOOT_PULSE;
    endcase
  end

  // Timer is loaded on the edge that enters a wait state.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = 32'd0;
    case (w_next)
      ST_BOOT_WAIT: begin
        w_load     = (r_state != ST_BOOT_WAIT);
        w_load_val = BOOT_LOAD;
      end
      ST_CLR_WAIT: begin
        w_load     = (r_state != ST_CLR_WAIT);
        w_load_val = CLEAR_LOAD;
      end
      ST_CHR_WAIT: begin
        w_load     = (r_state != ST_CHR_WAIT);
        w_load_val = CHAR_LOAD;
      end
      default: ;
    endcase
  end

  assign w_nibble = r_value_q[{w_idx_next, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy        <= 1'b1;
      r_lcd_init    <= 1'b0;
      r_lcd_enviar  <= 1'b0;
      r_lcd_limpiar <= 1'b0;
      r_lcd_info    <= 8'h00;
    end else begin
      r_busy        <= (w_next != ST_READY);
      r_lcd_init    <= (r_state == ST_BOOT_PULSE) && !r_lcd_init;
      r_lcd_enviar  <= (w_next == ST_CHR_PULSE);
      r_lcd_limpiar <= (w_next == ST_CLR_PULSE);
      if (w_next == ST_CHR_PULSE) begin
        r_lcd_info <= hex_to_ascii(w_nibble);
      end
    end
  end

  assign busy        = r_busy;
  assign lcd_init    = r_lcd_init;
  assign lcd_enviar  = r_lcd_enviar;
  assign lcd_limpiar = r_lcd_limpiar;
  assign lcd_info    = r_lcd_info;

endmodule

// File: tb/tb_lcd_hex_writer.sv
// tb_lcd_hex_writer: scoreboard bench for lcd_hex_writer.
// Expected init/clear/character pulses (kind, character, cycle) are queued
// when stimulus is driven and popped by a monitor as the DUT emits pulses.
module tb_lcd_hex_writer;

  localparam int BOOT  = 20;
  localparam int CLR   = 10;
  localparam int CHR   = 4;
  localparam int WIN   = (1 + CLR) + 8 * (1 + CHR);
  localparam int K_INIT = 0;
  localparam int K_CLR  = 1;
  localparam int K_CHR  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = 32'd0;
  logic        busy;
  logic        lcd_init;
  logic        lcd_enviar;
  logic        lcd_limpiar;
  logic [7:0]  lcd_info;

  lcd_hex_writer #(
    .BOOT_CYCLES  (BOOT),
    .CLEAR_CYCLES (CLR),
    .CHAR_CYCLES  (CHR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .value       (value),
    .busy        (busy),
    .lcd_init    (lcd_init),
    .lcd_enviar  (lcd_enviar),
    .lcd_limpiar (lcd_limpiar),
    .lcd_info    (lcd_info)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t  q[$];
  int   cyc = 0;
  logic rst_q;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  function automatic void push_write(input logic [31:0] v, input int a, input int nch);
    ev_t e;
    e.kind = K_CLR; e.data = 8'h00; e.cyc = a;
    q.push_back(e);
    for (int k = 0; k < nch; k++) begin
      e.kind = K_CHR;
      e.data = exp_char(v[31 - 4 * k -: 4]);
      e.cyc  = a + 1 + CLR + k * (1 + CHR);
      q.push_back(e);
    end
  endfunction

  function automatic void push_init(input int c);
    ev_t e;
    e.kind = K_INIT; e.data = 8'h00; e.cyc = c;
    q.push_back(e);
  endfunction

  // Monitor: pops the scoreboard on every pulse and checks that lcd_info
  // holds between character pulses (and is 0 right after reset).
  logic [7:0] last_info = 8'h00;
  always @(negedge clk) begin
    ev_t e;
    int  kind;
    if (rst_q === 1'b1) last_info = 8'h00;
    if (lcd_init || lcd_limpiar || lcd_enviar) begin
      chk("single_pulse", $countones({lcd_init, lcd_limpiar, lcd_enviar}), 1);
      kind = lcd_init ? K_INIT : (lcd_limpiar ? K_CLR : K_CHR);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, lcd_init, lcd_limpiar, lcd_enviar}, 0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", kind, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
        if (e.kind == K_CHR) chk("char", lcd_info, e.data);
      end
    end
    if (lcd_enviar) begin
      last_info = lcd_info;
    end else if (cyc > 0) begin
      chk("info_hold", lcd_info, last_info);
    end
  end

  task automatic wait_ready(input string tag, output int rc);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk({tag, "_timeout"}, busy, 0);
    rc = cyc;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_init"}, lcd_init, 0);
    chk({tag, "_enviar"}, lcd_enviar, 0);
    chk({tag, "_limpiar"}, lcd_limpiar, 0);
    chk({tag, "_info"}, lcd_info, 8'h00);
  endtask

  task automatic do_write(input logic [31:0] v, output int a);
    int rc;
    wait_ready("pre_write", rc);
    start = 1'b1;
    value = v;
    a = cyc + 1;
    push_write(v, a, 8);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  initial begin
    int r, rc, a;
    logic [31:0] vals[3];

    // Reset and boot
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    r = cyc + 1;
    push_init(r);
    @(negedge clk);
    chk("init_high", lcd_init, 1);
    @(negedge clk);
    chk("init_one_cycle", lcd_init, 0);
    wait_ready("boot", rc);
    chk("boot_busy_fall", rc - r, BOOT + 1);

    // Basic and boundary writes
    vals[0] = 32'h1234ABCD;
    vals[1] = 32'h00000000;
    vals[2] = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      do_write(vals[i], a);
      wait_ready("write", rc);
      chk("busy_window", rc - a, WIN);
    end
    chk("info_after_ff", lcd_info, 8'h46);

    // Start and value changes while busy are ignored
    do_write(32'h89ABCDEF, a);
    while (cyc < a + 20) @(negedge clk);
    start = 1'b1;
    value = 32'h00000000;
    @(negedge clk);
    start = 1'b0;
    wait_ready("busy_start", rc);
    chk("busy_start_window", rc - a, WIN);
    repeat (20) @(negedge clk);
    chk("busy_start_idle", busy, 0);
    chk("info_kept_ready", lcd_info, 8'h46);

    // Back-to-back with start held high
    wait_ready("b2b_pre", rc);
    start = 1'b1;
    value = 32'h5A5A0F0F;
    a = cyc + 1;
    push_write(value, a, 8);
    push_write(value, a + WIN + 1, 8);
    @(negedge clk);
    wait_ready("b2b_first", rc);
    chk("b2b_first_window", rc - a, WIN);
    @(negedge clk);
    chk("b2b_restart_busy", busy, 1);
    start = 1'b0;
    wait_ready("b2b_second", rc);
    chk("b2b_second_window", rc - (a + WIN + 1), WIN);

    // Reset during the third character wait
    start = 1'b1;
    value = 32'hC0FFEE42;
    a = cyc + 1;
    push_write(value, a, 3);
    @(negedge clk);
    start = 1'b0;
    while (cyc < a + 1 + CLR + 2 * (1 + CHR) + 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    chk("midreset_queue_drained", q.size(), 0);
    reset = 1'b0;
    r = cyc + 1;
    push_init(r);
    @(negedge clk);
    wait_ready("reboot", rc);
    chk("reboot_busy_fall", rc - r, BOOT + 1);
    repeat (30) @(negedge clk);
    chk("reboot_idle_busy", busy, 0);

    // Normal operation resumes
    do_write(32'hDEADBEEF, a);
    wait_ready("final", rc);
    chk("final_window", rc - a, WIN);
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lcd_hex_writer.md
# lcd_hex_writer

Command sequencer that sits directly upstream of the character LCD controller and drives its `init`, `enviar`, `limpiar` and `info` inputs. After reset it triggers LCD initialisation and waits for it to finish. On each `start` strobe it latches a 32-bit value, clears the display and writes the value as 8 uppercase hex ASCII characters, most significant nibble first. It gives the rest of the design a simple "display this word" port with a `busy` flag.

## Interface

Parameters:
- `BOOT_CYCLES`, default 1000000: cycles to wait after the init pulse before the LCD accepts commands.
- `CLEAR_CYCLES`, default 82000: cycles to wait after a clear command.
- `CHAR_CYCLES`, default 2000: cycles to wait after each character command.

Ports (reset is `reset`, synchronous, active-high; clock is `clk`):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request to display `value`; sampled only in READY.
- `value`  in  32  word to display; latched when `start` is accepted.
- `busy`  out  1  high while booting or writing; `start` is ignored while high.
- `lcd_init`  out  1  one-cycle pulse to the LCD controller `init`.
- `lcd_enviar`  out  1  one-cycle pulse: write the character on `lcd_info`.
- `lcd_limpiar`  out  1  one-cycle pulse: clear the display.
- `lcd_info`  out  8  ASCII character; held stable through the whole character wait.

## Operation

- All outputs are registered.
- Reset values:
  - `lcd_init`, `lcd_enviar`, `lcd_limpiar` = 0.
  - `lcd_info` = 8'h00.
  - `busy` = 1.
  - State = BOOT_PULSE; nibble index = 7; timer = 0.
- States:
  - BOOT_PULSE: `lcd_init` = 1 for 1 cycle, then go to BOOT_WAIT.
  - BOOT_WAIT: wait exactly BOOT_CYCLES cycles, then go to READY.
  - READY: `busy` = 0. If `start` = 1, latch `value`, set index to 7, go to CLR_PULSE. Otherwise stay.
  - CLR_PULSE: `lcd_limpiar` = 1 for 1 cycle, then go to CLR_WAIT.
  - CLR_WAIT: wait CLEAR_CYCLES cycles, then go to CHR_PULSE.
  - CHR_PULSE: `lcd_enviar` = 1 for 1 cycle, with `lcd_info` = ASCII(nibble[index]). Then go to CHR_WAIT.
  - CHR_WAIT: wait CHAR_CYCLES cycles. When done, if index = 0 go to READY; otherwise decrement index and go to CHR_PULSE.
- Hex-to-ASCII mapping:
  - Nibble n in 0–9 maps to 8'h30+n.
  - Nibble n in 10–15 maps to 8'h41+(n−10) (uppercase).
- Nibble selection: index i selects `value_q[4i+3:4i]`.
- Boundary conditions:
  - `start` while busy: ignored, not queued.
  - `start` held high continuously: a new write begins on every return to READY.
  - `value` changing mid-write: no effect, because the latched copy is used.
  - `lcd_enviar` and `lcd_limpiar` are never high in the same cycle.
  - `reset` mid-operation: immediately returns to BOOT_PULSE and re-initialises the LCD.
  - `lcd_info` keeps its last character until the next CHR_PULSE, and keeps it in READY as well.
  - A wait parameter of 0 makes the wait state last exactly 1 cycle.

## Timing

- Reset release: `lcd_init` is high in the first cycle after `reset` falls.
- `busy` falls 1 + BOOT_CYCLES cycles later.
- `start` is accepted at clock edge T:
  - `busy` = 1 and `lcd_limpiar` = 1 during cycle T+1.
  - The first `lcd_enviar` pulse occurs at cycle T+2+CLEAR_CYCLES.
  - Successive `lcd_enviar` pulses are spaced 1+CHAR_CYCLES cycles apart.
- Busy window after acceptance: exactly (1+CLEAR_CYCLES) + 8·(1+CHAR_CYCLES) cycles. The next `start` can be accepted on the cycle after that window ends.
- Timer: 32-bit down-counter, loaded with the wait value minus 1 on entry to a wait state. The wait exits when the counter reaches 0.

## Structure

- Shared package `lcd_pkg` holds:
  - State encodings.
  - ASCII constants `ASCII_0` (8'h30) and `ASCII_A` (8'h41).
  - Function `hex_to_ascii(nibble)`.
- One sub-module `lcd_wait_timer`:
  - Inputs: load, load value[31:0].
  - Output: `done` pulse.
  - The down-counter used by BOOT_WAIT, CLR_WAIT and CHR_WAIT.
- The FSM, the latched `value_q` and the index counter live in the top module.

## Test plan

Parameters for all scenarios: BOOT_CYCLES=20, CLEAR_CYCLES=10, CHAR_CYCLES=4.

- **Reset / boot:** release `reset`.
  - `lcd_init` is high for exactly 1 cycle.
  - `busy` falls 21 cycles after release.
  - All other outputs stay 0.
- **Basic write:** `start` with `value` = 32'h1234ABCD.
  - One `lcd_limpiar` pulse, followed by `lcd_enviar` pulses with `lcd_info` = 31,32,33,34,41,42,43,44 (hex).
  - Pulses are 5 cycles apart.
  - `busy` is high for exactly 51 cycles.
- **Boundary values:** `value` = 32'h00000000 gives 8 × 8'h30; `value` = 32'hFFFFFFFF gives 8 × 8'h46.
- **Start while busy:**
  - Pulse `start` with a new value mid-write: the current sequence is unchanged and no second write occurs.
  - Change `value` mid-write: the displayed characters are unchanged.
- **Back-to-back:** hold `start` high.
  - The second `lcd_limpiar` occurs exactly 1 cycle after `busy` falls.
  - The first and second sequences are identical.
- **Mid-operation reset:** assert `reset` during the 3rd character wait.
  - Outputs take their reset values on the next cycle.
  - `lcd_init` pulses again after release.
  - No further `lcd_enviar` occurs until a new `start`.
